// File: rtl/hpu_hpm_unit.sv
// hpu_hpm_unit: cycle/instret/programmable event counters with inhibit, halt freeze, sticky overflow IRQ and registered CSR read.
module hpu_hpm_unit #(
  parameter int CNT_NUM = 5,
  parameter int EVT_NUM = 24,
  parameter int SUM_W = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rd_en_i,
  input  logic [11:0]              raddr_i,
  input  logic                     wr_en_i,
  input  logic [11:0]              waddr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o,
  output logic                     rdata_vld_o,
  input  logic [SUM_W-1:0]         retire_sum_i,
  input  logic [EVT_NUM*SUM_W-1:0] evt_cnt_i,
  input  logic                     halt_i,
  input  logic                     stopcount_i,
  output logic                     ovf_irq_o
);
  localparam int NC = CNT_NUM + 3;
  localparam int IW = SUM_W + 5;
  localparam logic [63:0] NC_ONES = (64'd1 << NC) - 64'd1;
  localparam logic [31:0] CMASK = NC_ONES[31:0] & ~32'h2;
  localparam logic [63:0] EV_ONES = (64'd1 << (8 + EVT_NUM)) - 64'd1;
  localparam logic [31:0] EMASK = EV_ONES[31:0];

  logic [63:0]              cnt [NC];
  logic [31:0]              evt [NC];
  logic [31:0]              inhibit, ovf_status, ovf_en;
  logic [EVT_NUM*SUM_W-1:0] evt_q;
  logic [SUM_W-1:0]         ret_q;
  logic [IW-1:0]            sum [NC];
  logic [63:0]              inc [NC];
  logic [64:0]              nxt [NC];
  logic [NC-1:0]            any_v, en, wr_k;
  logic [31:0]              ovf_set, revt, rmux;
  logic [63:0]              rcnt;
  logic                     frz, wcnt;
  logic [4:0]               widx, ridx;

  always_comb begin
    frz = halt_i & stopcount_i;
    widx = waddr_i[4:0];
    wcnt = wr_en_i && waddr_i[11:8] == 4'hb && waddr_i[6:5] == 2'b00;
    ovf_set = '0;
    for (int k = 0; k < NC; k++) begin
      sum[k] = '0;
      any_v[k] = 1'b0;
      for (int e = 0; e < EVT_NUM; e++) begin
        sum[k] = sum[k] + (evt[k][8+e] ? {5'd0, evt_q[e*SUM_W +: SUM_W]} : '0);
        any_v[k] = any_v[k] | (evt[k][8+e] & |evt_q[e*SUM_W +: SUM_W]);
      end
      inc[k] = k == 0 ? 64'd1 : k == 2 ? 64'(ret_q) : evt[k][7:0] == 8'd1 ? 64'(sum[k]) : {63'd0, any_v[k]};
      en[k] = CMASK[k] && !inhibit[k] && !frz && (k < 3 || evt[k][7:0] == 8'd1 || evt[k][7:0] == 8'd2);
      wr_k[k] = wcnt && CMASK[k] && int'(widx) == k;
      nxt[k] = {1'b0, cnt[k]} + {1'b0, inc[k]};
      // a CSR write replaces the increment, so it cannot overflow that cycle
      ovf_set[k] = en[k] && !wr_k[k] && nxt[k][64];
    end
  end

  always_comb begin
    ridx = raddr_i[4:0];
    rcnt = '0;
    revt = '0;
    for (int k = 0; k < NC; k++) begin
      rcnt = int'(ridx) == k ? cnt[k] : rcnt;
      revt = int'(ridx) == k ? evt[k] : revt;
    end
    rmux = raddr_i[11:8] == 4'hb && raddr_i[6:5] == 2'b00 && CMASK[ridx] ? (raddr_i[7] ? rcnt[63:32] : rcnt[31:0])
         : raddr_i == 12'h320 ? inhibit
         : raddr_i[11:5] == 7'h19 && CMASK[ridx] && ridx >= 5'd3 ? revt
         : raddr_i == 12'h7c0 ? ovf_status
         : raddr_i == 12'h7c1 ? ovf_en : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_q <= '0;
      ret_q <= '0;
      inhibit <= '0;
      ovf_status <= '0;
      ovf_en <= '0;
      ovf_irq_o <= 1'b0;
      rdata_o <= '0;
      rdata_vld_o <= 1'b0;
      for (int k = 0; k < NC; k++) begin
        cnt[k] <= '0;
        evt[k] <= '0;
      end
    end else begin
      evt_q <= evt_cnt_i;
      ret_q <= retire_sum_i;
      rdata_vld_o <= rd_en_i;
      if (rd_en_i) rdata_o <= rmux;
      if (wr_en_i && waddr_i == 12'h320) inhibit <= wdata_i & CMASK;
      if (wr_en_i && waddr_i == 12'h7c1) ovf_en <= wdata_i & CMASK;
      ovf_status <= (ovf_status & ~(wr_en_i && waddr_i == 12'h7c0 ? wdata_i : '0)) | ovf_set;
      ovf_irq_o <= |(ovf_status & ovf_en);
      for (int k = 0; k < NC; k++) begin
        if (wr_k[k]) cnt[k] <= waddr_i[7] ? {wdata_i, cnt[k][31:0]} : {cnt[k][63:32], wdata_i};
        else if (en[k]) cnt[k] <= nxt[k][63:0];
        if (wr_en_i && k >= 3 && waddr_i == 12'h320 + 12'(k)) evt[k] <= wdata_i & EMASK;
      end
    end
  end
endmodule

// File: tb/tb_hpu_hpm_unit.sv
// tb_hpu_hpm_unit: directed register-map table plus hand sequences for counting, overflow, inhibit, halt and reset.
module tb_hpu_hpm_unit;
  localparam int CN = 5;
  localparam int EN = 20;
  localparam int SW = 3;

  logic          clk, rst, rd_en, wr_en, rvld, halt, stop, irq;
  logic [11:0]   raddr, waddr;
  logic [31:0]   wdata, rdata;
  logic [SW-1:0] ret;
  logic [EN*SW-1:0] ev;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [31:0] d;
    string       nm;
  } vec_t;
  vec_t tv[$];

  hpu_hpm_unit #(.CNT_NUM(CN), .EVT_NUM(EN), .SUM_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .raddr_i(raddr), .wr_en_i(wr_en),
    .waddr_i(waddr), .wdata_i(wdata), .rdata_o(rdata), .rdata_vld_o(rvld),
    .retire_sum_i(ret), .evt_cnt_i(ev), .halt_i(halt), .stopcount_i(stop), .ovf_irq_o(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rdchk(input string nm, input logic [11:0] a, input logic [31:0] exp);
    rd_en = 1'b1;
    raddr = a;
    @(negedge clk);
    chk({nm, "_vld"}, 32'(rvld), 32'd1);
    chk(nm, rdata, exp);
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    waddr = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse(input logic [EN*SW-1:0] v);
    ev = v;
    @(negedge clk);
    ev = '0;
    repeat (2) @(negedge clk);
  endtask

  function automatic void add(input bit w, input logic [11:0] a, input logic [31:0] d, input string nm);
    vec_t v;
    v.wr = w;
    v.a = a;
    v.d = d;
    v.nm = nm;
    tv.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; raddr = '0; waddr = '0; wdata = '0;
    ret = '0; ev = '0; halt = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_vld", 32'(rvld), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rdchk("cyc10", 12'hb00, 32'd10);
    rdchk("cyc11", 12'hb00, 32'd11);
    @(negedge clk);
    chk("vld_pulse", 32'(rvld), 32'd0);
    chk("rdata_hold", rdata, 32'd11);

    add(0, 12'h320, 32'h0, "inh_rst");
    add(0, 12'h323, 32'h0, "ev3_rst");
    add(0, 12'h7c0, 32'h0, "ovf_rst");
    add(0, 12'h7c1, 32'h0, "irqen_rst");
    add(0, 12'hb03, 32'h0, "c3lo_rst");
    add(0, 12'hb83, 32'h0, "c3hi_rst");
    add(1, 12'h320, 32'hffffffff, "");
    add(0, 12'h320, 32'h000000fd, "inh_mask");
    add(1, 12'h323, 32'hffffffff, "");
    add(0, 12'h323, 32'h0fffffff, "ev3_mask");
    add(1, 12'h7c1, 32'hffffffff, "");
    add(0, 12'h7c1, 32'h000000fd, "irqen_mask");
    add(1, 12'hb01, 32'h00001234, "");
    add(0, 12'hb01, 32'h0, "c1_lo");
    add(0, 12'hb81, 32'h0, "c1_hi");
    add(1, 12'h7ff, 32'h00005a5a, "");
    add(0, 12'h7ff, 32'h0, "unmapped");
    add(1, 12'h322, 32'h000000ff, "");
    add(0, 12'h322, 32'h0, "ev2");
    add(1, 12'h328, 32'h000000ff, "");
    add(0, 12'h328, 32'h0, "ev8");
    add(1, 12'hb08, 32'h00000055, "");
    add(0, 12'hb08, 32'h0, "c8");
    add(1, 12'hb05, 32'haaaa5555, "");
    add(1, 12'hb85, 32'h00001234, "");
    add(0, 12'hb05, 32'haaaa5555, "c5lo");
    add(0, 12'hb85, 32'h00001234, "c5hi");
    add(1, 12'h320, 32'h0, "");
    add(1, 12'h323, 32'h0, "");
    add(1, 12'h7c1, 32'h0, "");
    add(0, 12'h320, 32'h0, "inh_clr");
    add(0, 12'h7c1, 32'h0, "irqen_clr");
    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].wr) wr(tv[i].a, tv[i].d);
      else rdchk(tv[i].nm, tv[i].a, tv[i].d);
    end

    // SUM/ANY modes and pipeline latency
    wr(12'h323, 32'h00000301);
    ev = 60'h1d3;
    @(negedge clk);
    ev = '0;
    rdchk("sum_early", 12'hb03, 32'd0);
    rdchk("sum5", 12'hb03, 32'd5);
    wr(12'h323, 32'h00000302);
    pulse(60'h1d3);
    rdchk("any", 12'hb03, 32'd6);
    pulse(60'h1c0);
    rdchk("any_unsel", 12'hb03, 32'd6);
    wr(12'h324, 32'h0fffff01);
    pulse({(EN*SW){1'b1}});
    rdchk("sum_all", 12'hb04, 32'h8c);

    // 64-bit wrap, overflow status and irq
    wr(12'h323, 32'h00000101);
    wr(12'hb83, 32'hffffffff);
    wr(12'hb03, 32'hfffffffe);
    wr(12'h7c1, 32'h00000008);
    rdchk("c3hi_set", 12'hb83, 32'hffffffff);
    rdchk("c3lo_set", 12'hb03, 32'hfffffffe);
    ev = 60'h1;
    repeat (2) @(negedge clk);
    ev = '0;
    @(negedge clk);
    chk("irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_rise", 32'(irq), 32'd1);
    rdchk("wrap_lo", 12'hb03, 32'd0);
    rdchk("wrap_hi", 12'hb83, 32'd0);
    rdchk("ovf_set", 12'h7c0, 32'h8);
    wr(12'h7c0, 32'h00000008);
    chk("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    chk("irq_fall", 32'(irq), 32'd0);
    rdchk("ovf_clr", 12'h7c0, 32'h0);

    // write beats same-cycle increment
    ev = 60'h3;
    @(negedge clk);
    ev = '0;
    wr(12'hb04, 32'h00000010);
    repeat (2) @(negedge clk);
    rdchk("wr_wins", 12'hb04, 32'h10);
    rdchk("wr_wins_hi", 12'hb84, 32'h0);

    // overflow set beats same-cycle W1C
    wr(12'hb83, 32'hffffffff);
    wr(12'hb03, 32'hffffffff);
    ev = 60'h1;
    @(negedge clk);
    ev = '0;
    wr(12'h7c0, 32'h00000008);
    repeat (2) @(negedge clk);
    rdchk("ovf_w1c_race", 12'h7c0, 32'h8);
    rdchk("race_wrap", 12'hb03, 32'd0);
    chk("irq_race", 32'(irq), 32'd1);

    // instret and mcountinhibit
    ret = 3'd3;
    repeat (2) @(negedge clk);
    ret = '0;
    repeat (2) @(negedge clk);
    rdchk("instret", 12'hb02, 32'd6);
    wr(12'h320, 32'h00000005);
    wr(12'hb00, 32'h00001000);
    wr(12'hb80, 32'h0);
    repeat (5) @(negedge clk);
    rdchk("cyc_inh", 12'hb00, 32'h1000);
    rdchk("cyc_inh_hi", 12'hb80, 32'h0);
    ret = 3'd3;
    repeat (2) @(negedge clk);
    ret = '0;
    repeat (2) @(negedge clk);
    rdchk("instret_inh", 12'hb02, 32'd6);
    wr(12'h320, 32'h0);
    rdchk("cyc_go0", 12'hb00, 32'h1000);
    rdchk("cyc_go1", 12'hb00, 32'h1001);

    // debug halt with stopcount
    halt = 1'b1;
    stop = 1'b1;
    wr(12'hb00, 32'h00002000);
    repeat (3) @(negedge clk);
    rdchk("halt_cyc", 12'hb00, 32'h2000);
    pulse(60'h1);
    rdchk("halt_c3", 12'hb03, 32'd0);
    ret = 3'd2;
    @(negedge clk);
    ret = '0;
    repeat (2) @(negedge clk);
    rdchk("halt_ir", 12'hb02, 32'd6);
    stop = 1'b0;
    rdchk("halt_nostop0", 12'hb00, 32'h2000);
    rdchk("halt_nostop1", 12'hb00, 32'h2001);
    halt = 1'b0;
    pulse(60'h1);
    rdchk("resume_c3", 12'hb03, 32'd1);

    // async reset mid-operation drops the pending retire
    chk("irq_pre_rst", 32'(irq), 32'd1);
    ret = 3'd5;
    @(negedge clk);
    rst = 1'b1;
    ret = '0;
    #1;
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_vld", 32'(rvld), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rdchk("rst_cyc", 12'hb00, 32'd0);
    rdchk("rst_ir", 12'hb02, 32'd0);
    rdchk("rst_ovf", 12'h7c0, 32'd0);
    rdchk("rst_ev3", 12'h323, 32'd0);
    rdchk("rst_c4", 12'hb04, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
